round_robin_dispatcher: RTL

- 1-to-N distributor: takes one valid/ready input stream and deals beats to N consumer ports in round-robin order.
- Skips consumer ports whose enable bit is low.
- Counterpart of the team's N-to-1 round-robin arbiter; sits on the fan-out side of shared-resource paths, e.g. a work queue feeding N engines.
- Output is registered with a one-beat holding stage, giving full throughput when consumers are ready.

---
 rtl/rr_pkg.sv | 24 ++
 rtl/rr_next_onehot.sv | 26 ++
 rtl/round_robin_dispatcher.sv | 110 +++++++++++
 3 files changed

// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin dispatcher family.
// Holds default sizing, the stall counter width and its saturating increment.
package rr_pkg;

  // Default sizing for a dispatcher instance.
  localparam int unsigned RrDefaultDw    = 3;
  localparam int unsigned RrDefaultDataW = 32;

  // Stall counter width and its saturation value.
  localparam int unsigned              StallCntW   = 16;
  localparam logic [StallCntW-1:0]     StallCntMax = 16'hFFFF;

  // Increment that sticks at the maximum instead of wrapping.
  function automatic logic [StallCntW-1:0] stall_sat_inc(input logic [StallCntW-1:0] cnt);
    logic [StallCntW-1:0] res;
    if (cnt == StallCntMax) begin
      res = cnt;
    end else begin
      res = cnt + StallCntW'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_next_onehot.sv
// Round-robin next-target finder.
// Returns the first set bit of mask strictly after the one-hot ptr, wrapping
// from bit W-1 back to bit 0. Output is zero when mask is zero.
module rr_next_onehot #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] mask,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] next_onehot
);

  logic [2*W-1:0] req2;
  logic [2*W-1:0] base;
  logic [2*W-1:0] gnt2;

  // Doubling the mask lets the search run past bit W-1 without a wrap case;
  // req - base borrows up to the first request at or above base, and the
  // and-not isolates that bit. Folding the halves returns to W bits.
  always_comb begin
    req2        = {mask, mask};
    base        = {{W{1'b0}}, ptr} << 1;
    gnt2        = req2 & ~(req2 - base);
    next_onehot = gnt2[W-1:0] | gnt2[2*W-1:W];
  end

endmodule

// File: rtl/round_robin_dispatcher.sv
// 1-to-N round-robin dispatcher with a one-beat registered holding stage.
// Beats from a single valid/ready stream are dealt to enabled consumer ports
// in turn; the held beat is presented one-hot on m_valid with shared m_data.
// Optional build macro: RR_DISPATCH_STALL_CNT_EN adds a saturating count of
// cycles in which a held beat could not be delivered. Without it stall_cnt
// reads zero and no counter flops exist.
module round_robin_dispatcher
  import rr_pkg::*;
#(
  parameter int unsigned DW     = RrDefaultDw,
  parameter int unsigned DATA_W = RrDefaultDataW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic [DW-1:0]        port_en,
  output logic [DW-1:0]        m_valid,
  input  logic [DW-1:0]        m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic [StallCntW-1:0] stall_cnt
);

  // Holding-stage occupancy.
  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  // Reset pointer sits on the top port so the first beat lands on the
  // lowest enabled port.
  localparam logic [DW-1:0] PtrRst = {1'b1, {(DW-1){1'b0}}};

  logic [0:0]        state_q, state_d;
  logic [DW-1:0]     m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DW-1:0]     ptr_q, ptr_d;
  logic [DW-1:0]     next_tgt;
  logic              full;
  logic              pop;
  logic              accept;

  rr_next_onehot #(
    .W (DW)
  ) u_next (
    .mask        (port_en),
    .ptr         (ptr_q),
    .next_onehot (next_tgt)
  );

  // Handshake decode; only the targeted port's ready can pop the beat.
  always_comb begin
    full    = (state_q == StFull);
    pop     = |(m_valid_q & m_ready);
    s_ready = (|port_en) & (~full | pop);
    accept  = s_valid & s_ready;
  end

  // Next-state: accept loads (and overrides a same-cycle pop), pop alone empties.
  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    ptr_d     = ptr_q;
    if (accept) begin
      state_d   = StFull;
      m_valid_d = next_tgt;
      m_data_d  = s_data;
      ptr_d     = next_tgt;
    end else if (pop) begin
      state_d   = StEmpty;
      m_valid_d = '0;
    end
  end

  // Holding stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      m_valid_q <= '0;
      m_data_q  <= '0;
      ptr_q     <= PtrRst;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      ptr_q     <= ptr_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

`ifdef RR_DISPATCH_STALL_CNT_EN
  logic [StallCntW-1:0] stall_cnt_q;

  // Count cycles where a beat is held but its port did not take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (full && !pop) begin
      stall_cnt_q <= stall_sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
